// File: rtl/lvds_rx_frame_align.sv
`default_nettype none
// ============================================================================
// Module      : lvds_rx_frame_align
// Description : Frame-clock lane word aligner for a 9-channel 6x LVDS
//               receiver. Pulses rx_data_align until lane 8 carries
//               FCLK_PATTERN, then forwards the 8 data lanes as registered,
//               qualified samples and re-aligns on loss of frame.
//               Optional frame-error counter: define LVDS_RX_FRAME_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lvds_rx_frame_align #(
  parameter logic [5:0]  FCLK_PATTERN       = 6'b111000,
  parameter int unsigned SETTLE_CYCLES      = 8,
  parameter int unsigned MATCH_CYCLES       = 4,
  parameter int unsigned LOSS_CYCLES        = 3,
  parameter int unsigned ALIGN_PULSE_CYCLES = 2
) (
  input  logic        rx_clk,
  input  logic        reset,
  input  logic        rx_locked,
  input  logic [53:0] rx_data,
  output logic        rx_data_align,
  output logic [47:0] sample_data,
  output logic        sample_valid,
  output logic        aligned,
  output logic        align_fail,
  output logic [2:0]  slip_count,
  output logic [15:0] err_count
);

  // Terminal values of the down-sized phase counters (count from 0).
  localparam logic [7:0] c_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] c_MATCH_LAST  = 4'(MATCH_CYCLES - 1);
  localparam logic [3:0] c_LOSS_LAST   = 4'(LOSS_CYCLES - 1);
  localparam logic [2:0] c_PULSE_LAST  = 3'(ALIGN_PULSE_CYCLES - 1);
  // A 6x serialiser has six bit positions, so slips wrap after six.
  localparam logic [2:0] c_SLIP_LAST   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CHECK   = 3'd2,
    ST_SLIP    = 3'd3,
    ST_ALIGNED = 3'd4
  } state_t;

  state_t      state_q;
  logic [7:0]  settle_cnt_q;
  logic [3:0]  match_cnt_q;
  logic [3:0]  loss_cnt_q;
  logic [2:0]  pulse_cnt_q;
  logic [2:0]  slip_count_q;
  logic        align_fail_q;
  logic        aligned_q;
  logic        rx_data_align_q;
  logic        sample_valid_q;
  logic [47:0] sample_data_q;

  logic        frame_match;

  // Frame lane compared against the expected word every cycle.
  assign frame_match = (rx_data[53:48] == FCLK_PATTERN);

  // Alignment FSM: all control outputs are registered alongside the state.
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      settle_cnt_q    <= '0;
      match_cnt_q     <= '0;
      loss_cnt_q      <= '0;
      pulse_cnt_q     <= '0;
      slip_count_q    <= '0;
      align_fail_q    <= 1'b0;
      aligned_q       <= 1'b0;
      rx_data_align_q <= 1'b0;
    end else if ((state_q != ST_IDLE) && !rx_locked) begin
      // Lost PLL lock: abandon everything (including a slip pulse in flight)
      // but keep the sticky failure flag for software to inspect.
      state_q         <= ST_IDLE;
      settle_cnt_q    <= '0;
      match_cnt_q     <= '0;
      loss_cnt_q      <= '0;
      pulse_cnt_q     <= '0;
      aligned_q       <= 1'b0;
      rx_data_align_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rx_data_align_q <= 1'b0;
          aligned_q       <= 1'b0;
          if (rx_locked) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
            slip_count_q <= '0;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt_q == c_SETTLE_LAST) begin
            state_q      <= ST_CHECK;
            settle_cnt_q <= '0;
            match_cnt_q  <= '0;
          end else begin
            settle_cnt_q <= settle_cnt_q + 8'd1;
          end
        end

        ST_CHECK: begin
          if (frame_match) begin
            if (match_cnt_q == c_MATCH_LAST) begin
              state_q      <= ST_ALIGNED;
              aligned_q    <= 1'b1;
              align_fail_q <= 1'b0;
              match_cnt_q  <= '0;
              loss_cnt_q   <= '0;
            end else begin
              match_cnt_q <= match_cnt_q + 4'd1;
            end
          end else begin
            // Start a bit-slip; the pulse is high from the first SLIP cycle.
            state_q         <= ST_SLIP;
            rx_data_align_q <= 1'b1;
            pulse_cnt_q     <= '0;
            match_cnt_q     <= '0;
            if (slip_count_q == c_SLIP_LAST) begin
              // Every bit position has been tried once without success.
              slip_count_q <= '0;
              align_fail_q <= 1'b1;
            end else begin
              slip_count_q <= slip_count_q + 3'd1;
            end
          end
        end

        ST_SLIP: begin
          if (pulse_cnt_q == c_PULSE_LAST) begin
            state_q         <= ST_SETTLE;
            rx_data_align_q <= 1'b0;
            pulse_cnt_q     <= '0;
            settle_cnt_q    <= '0;
          end else begin
            pulse_cnt_q <= pulse_cnt_q + 3'd1;
          end
        end

        ST_ALIGNED: begin
          if (!frame_match) begin
            if (loss_cnt_q == c_LOSS_LAST) begin
              // Re-verify without slipping: the word may only be glitching.
              state_q     <= ST_CHECK;
              aligned_q   <= 1'b0;
              loss_cnt_q  <= '0;
              match_cnt_q <= '0;
            end else begin
              loss_cnt_q <= loss_cnt_q + 4'd1;
            end
          end else begin
            loss_cnt_q <= '0;
          end
        end

        default: begin
          state_q         <= ST_IDLE;
          aligned_q       <= 1'b0;
          rx_data_align_q <= 1'b0;
        end
      endcase
    end
  end

  // Data path: one-cycle registered copy, qualified by an in-frame word.
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      sample_data_q  <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_data_q  <= rx_data[47:0];
      sample_valid_q <= rx_locked && (state_q == ST_ALIGNED) && frame_match;
    end
  end

`ifdef LVDS_RX_FRAME_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Saturating count of out-of-frame words seen while aligned; survives re-lock.
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if ((state_q == ST_ALIGNED) && !frame_match && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 16'd0;
`endif

  assign rx_data_align = rx_data_align_q;
  assign sample_data   = sample_data_q;
  assign sample_valid  = sample_valid_q;
  assign aligned       = aligned_q;
  assign align_fail    = align_fail_q;
  assign slip_count    = slip_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lvds_rx_frame_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_lvds_rx_frame_align
// Description : Self-checking bench for lvds_rx_frame_align with a bit-slip
//               receiver model and a sample_data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lvds_rx_frame_align;

  localparam logic [5:0] PAT = 6'b111000;
`ifdef LVDS_RX_FRAME_ERR_CNT_EN
  localparam int ERR_EXP = 5;
`else
  localparam int ERR_EXP = 0;
`endif

  logic        rx_clk = 1'b0;
  logic        reset;
  logic        rx_locked;
  logic [53:0] rx_data;
  logic        rx_data_align;
  logic [47:0] sample_data;
  logic        sample_valid;
  logic        aligned;
  logic        align_fail;
  logic [2:0]  slip_count;
  logic [15:0] err_count;

  lvds_rx_frame_align dut (
    .rx_clk        (rx_clk),
    .reset         (reset),
    .rx_locked     (rx_locked),
    .rx_data       (rx_data),
    .rx_data_align (rx_data_align),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .aligned       (aligned),
    .align_fail    (align_fail),
    .slip_count    (slip_count),
    .err_count     (err_count)
  );

  always #5 rx_clk = ~rx_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of expected sample_data, one entry per clock edge.
  logic [47:0] sb_q[$];

  // Receiver model: frame lane is PAT rotated by slip_ofs; each align pulse
  // moves it one bit towards alignment. force_en overrides the lane.
  int         slip_ofs  = 0;
  bit         force_en  = 1'b0;
  logic [5:0] force_val = 6'b000000;
  logic       align_prev = 1'b0;
  int         rises = 0;
  int         cur_w = 0;
  int         low_run = 0;
  int         pw_q[$];
  int         gap_q[$];

  function automatic logic [5:0] rotr6(input logic [5:0] v, input int n);
    logic [5:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[0], r[5:1]};
    return r;
  endfunction

  task automatic clear_stats();
    pw_q.delete();
    gap_q.delete();
    rises   = 0;
    low_run = 0;
    cur_w   = 0;
  endtask

  // Apply current controls plus fresh data, clock one edge, score sample_data,
  // then let the receiver model react to the align output.
  task automatic tick();
    logic [63:0] r;
    logic [47:0] d;
    logic [5:0]  fr;
    logic [47:0] exp_d;
    r  = {$urandom, $urandom};
    d  = r[47:0];
    fr = force_en ? force_val : rotr6(PAT, slip_ofs);
    rx_data = {fr, d};
    sb_q.push_back(reset ? 48'd0 : d);
    @(posedge rx_clk);
    #1;
    exp_d = sb_q.pop_front();
    n_checks++;
    if (sample_data !== exp_d) begin
      n_fail++;
      $display("FAIL sample_data: got %h expected %h", sample_data, exp_d);
    end
    if (rx_data_align) begin
      if (!align_prev) begin
        rises++;
        gap_q.push_back(low_run);
        cur_w    = 0;
        slip_ofs = (slip_ofs + 5) % 6;
      end
      cur_w++;
      low_run = 0;
    end else begin
      if (align_prev) pw_q.push_back(cur_w);
      low_run++;
    end
    align_prev = rx_data_align;
  endtask

  task automatic run_until_aligned(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!aligned && n < max);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_locked = 1'b0;
    tick(); tick();
    n_checks++; if (aligned !== 1'b0)       begin n_fail++; $display("FAIL reset_aligned: got %b expected 0", aligned); end
    n_checks++; if (rx_data_align !== 1'b0) begin n_fail++; $display("FAIL reset_align_pulse: got %b expected 0", rx_data_align); end
    n_checks++; if (sample_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
    n_checks++; if (align_fail !== 1'b0)    begin n_fail++; $display("FAIL reset_align_fail: got %b expected 0", align_fail); end
    n_checks++; if (slip_count !== 3'd0)    begin n_fail++; $display("FAIL reset_slip_count: got %0d expected 0", slip_count); end
    n_checks++; if (err_count !== 16'd0)    begin n_fail++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
  endtask

  task automatic test_lock_aligned();
    int n;
    clear_stats();
    slip_ofs = 0; force_en = 1'b0;
    reset = 1'b0; rx_locked = 1'b1;
    run_until_aligned(40, n);
    n_checks++; if (n !== 13)  begin n_fail++; $display("FAIL lock_align_latency: got %0d expected 13", n); end
    n_checks++; if (rises !== 0) begin n_fail++; $display("FAIL lock_no_pulse: got %0d expected 0", rises); end
    tick();
    n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL lock_valid: got %b expected 1", sample_valid); end
    n_checks++; if (slip_count !== 3'd0)   begin n_fail++; $display("FAIL lock_slip_count: got %0d expected 0", slip_count); end
  endtask

  task automatic test_bit_slip();
    int n;
    rx_locked = 1'b0; tick();
    clear_stats();
    slip_ofs = 2; rx_locked = 1'b1;
    // 1 + 8 settle + 1 check + 2 pulse, twice, then 8 settle + 4 matches.
    run_until_aligned(100, n);
    n_checks++; if (n !== 35) begin n_fail++; $display("FAIL slip_align_latency: got %0d expected 35", n); end
    n_checks++; if (!(pw_q.size() == 2 && pw_q[0] == 2 && pw_q[1] == 2)) begin
      n_fail++; $display("FAIL slip_pulse_widths: got %0d pulses expected 2 of width 2", pw_q.size());
    end
    n_checks++; if (!(gap_q.size() == 2 && gap_q[1] == 9)) begin
      n_fail++; $display("FAIL slip_pulse_gap: got %0d gaps expected second gap 9", gap_q.size());
    end
    n_checks++; if (slip_count !== 3'd2) begin n_fail++; $display("FAIL slip_count: got %0d expected 2", slip_count); end
    tick();
    n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL slip_valid: got %b expected 1", sample_valid); end
  endtask

  task automatic test_align_fail();
    int n;
    rx_locked = 1'b0; tick();
    clear_stats();
    force_en = 1'b1; force_val = 6'b000000; rx_locked = 1'b1;
    n = 0; while (rises < 5 && n < 200) begin tick(); n++; end
    n_checks++; if (slip_count !== 3'd5) begin n_fail++; $display("FAIL fail_slip5: got %0d expected 5", slip_count); end
    n_checks++; if (align_fail !== 1'b0) begin n_fail++; $display("FAIL fail_before6: got %b expected 0", align_fail); end
    n = 0; while (rises < 6 && n < 40) begin tick(); n++; end
    n_checks++; if (slip_count !== 3'd0) begin n_fail++; $display("FAIL fail_wrap: got %0d expected 0", slip_count); end
    n_checks++; if (align_fail !== 1'b1) begin n_fail++; $display("FAIL fail_set: got %b expected 1", align_fail); end
    n = 0; while (rises < 7 && n < 40) begin tick(); n++; end
    n_checks++; if (rises !== 7) begin n_fail++; $display("FAIL fail_pulses_continue: got %0d expected 7", rises); end
    n_checks++; if (align_fail !== 1'b1) begin n_fail++; $display("FAIL fail_sticky: got %b expected 1", align_fail); end
    force_en = 1'b0; slip_ofs = 0;
    run_until_aligned(60, n);
    n_checks++; if (n !== 14) begin n_fail++; $display("FAIL fail_recover_latency: got %0d expected 14", n); end
    n_checks++; if (align_fail !== 1'b0) begin n_fail++; $display("FAIL fail_cleared: got %b expected 0", align_fail); end
  endtask

  task automatic test_loss();
    int n;
    reset = 1'b1; tick();
    reset = 1'b0; rx_locked = 1'b1; force_en = 1'b0; slip_ofs = 0;
    clear_stats();
    run_until_aligned(40, n);
    n_checks++; if (n !== 13) begin n_fail++; $display("FAIL loss_initial_align: got %0d expected 13", n); end
    tick();
    force_en = 1'b1; force_val = 6'b000111;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL loss_bad_valid: got %b expected 0", sample_valid); end
      n_checks++; if (aligned !== 1'b1)      begin n_fail++; $display("FAIL loss_bad_aligned: got %b expected 1", aligned); end
    end
    force_en = 1'b0; tick();
    n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL loss_good_valid: got %b expected 1", sample_valid); end
    force_en = 1'b1;
    tick(); tick();
    n_checks++; if (aligned !== 1'b1) begin n_fail++; $display("FAIL loss_two_bad: got %b expected 1", aligned); end
    tick();
    n_checks++; if (aligned !== 1'b0) begin n_fail++; $display("FAIL loss_declared: got %b expected 0", aligned); end
    n_checks++; if (err_count !== 16'(ERR_EXP)) begin n_fail++; $display("FAIL loss_err_count: got %0d expected %0d", err_count, ERR_EXP); end
    // Back in CHECK: realign after exactly MATCH_CYCLES good words, no settle.
    force_en = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (aligned !== 1'b0) begin n_fail++; $display("FAIL loss_recheck_early: got %b expected 0", aligned); end
    tick();
    n_checks++; if (aligned !== 1'b1) begin n_fail++; $display("FAIL loss_recheck: got %b expected 1", aligned); end
    n_checks++; if (rises !== 0)      begin n_fail++; $display("FAIL loss_no_slip: got %0d expected 0", rises); end
  endtask

  task automatic test_lock_drop();
    int n;
    rx_locked = 1'b0; tick();
    clear_stats();
    slip_ofs = 2; force_en = 1'b0; rx_locked = 1'b1;
    n = 0; while (rises < 1 && n < 40) begin tick(); n++; end
    n_checks++; if (n !== 10) begin n_fail++; $display("FAIL drop_first_pulse: got %0d expected 10", n); end
    rx_locked = 1'b0; tick();
    n_checks++; if (rx_data_align !== 1'b0) begin n_fail++; $display("FAIL drop_truncate: got %b expected 0", rx_data_align); end
    n_checks++; if (aligned !== 1'b0)       begin n_fail++; $display("FAIL drop_aligned: got %b expected 0", aligned); end
    tick(); tick();
    n_checks++; if (rises !== 1) begin n_fail++; $display("FAIL drop_idle_no_pulse: got %0d expected 1", rises); end
    slip_ofs = 0; rx_locked = 1'b1; tick();
    n_checks++; if (slip_count !== 3'd0) begin n_fail++; $display("FAIL drop_relock_slip: got %0d expected 0", slip_count); end
    run_until_aligned(40, n);
    n_checks++; if (n !== 12) begin n_fail++; $display("FAIL drop_relock_settle: got %0d expected 12", n); end
  endtask

  task automatic test_reset_aligned();
    force_en = 1'b1; force_val = 6'b010101; tick();
    force_en = 1'b0;
    reset = 1'b1; tick();
    n_checks++; if (aligned !== 1'b0)      begin n_fail++; $display("FAIL rst_al_aligned: got %b expected 0", aligned); end
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rst_al_valid: got %b expected 0", sample_valid); end
    n_checks++; if (err_count !== 16'd0)   begin n_fail++; $display("FAIL rst_al_err: got %0d expected 0", err_count); end
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_slip();
    int n;
    rx_locked = 1'b0; tick();
    clear_stats();
    slip_ofs = 3; rx_locked = 1'b1;
    n = 0; while (rises < 1 && n < 40) begin tick(); n++; end
    n_checks++; if (slip_count !== 3'd1) begin n_fail++; $display("FAIL mid_slip_count: got %0d expected 1", slip_count); end
    reset = 1'b1; tick();
    n_checks++; if (rx_data_align !== 1'b0) begin n_fail++; $display("FAIL mid_slip_reset_pulse: got %b expected 0", rx_data_align); end
    n_checks++; if (slip_count !== 3'd0)    begin n_fail++; $display("FAIL mid_slip_reset_count: got %0d expected 0", slip_count); end
    reset = 1'b0; rx_locked = 1'b0; tick();
  endtask

  initial begin
    rx_data = '0;
    test_reset();
    test_lock_aligned();
    test_bit_slip();
    test_align_fail();
    test_loss();
    test_lock_drop();
    test_reset_aligned();
    test_reset_mid_slip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
